// File: rtl/gate_probe.sv
// gate_probe: one-at-a-time socket-pin probe engine (drive, settle, sample, respond).
// Optional GATE_PROBE_AUTO_RELEASE_EN releases all pins on the response handshake.
module gate_probe #(
  parameter int NPINS         = 12,
  parameter int SETTLE_CYCLES = 50,
  parameter int SAMPLE_CYCLES = 8
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [NPINS-1:0] req_drive_mask,
  input  logic [NPINS-1:0] req_drive_val,
  input  logic [3:0]       req_sense_idx,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_level,
  output logic             rsp_stable,
  output logic             rsp_err,
  output logic [NPINS-1:0] pins_dir,
  output logic [NPINS-1:0] pins_out,
  input  logic [NPINS-1:0] pins_in,
  output logic             busy
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int AW = $clog2(SAMPLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, RESPOND} state_t;

  state_t           state_q, state_d;
  logic [NPINS-1:0] sync1_q, sync2_q;
  logic [CW-1:0]    settle_cnt_q;
  logic [AW-1:0]    sample_cnt_q, ones_q, ones_sum;
  logic [3:0]       sense_idx_q;
  logic             accept, reject, sample_done, handshake, sense_bit, req_bad;

  // NOTE: every clocked register uses non-blocking assignment so all flops
  // update together from pre-edge values, matching the hardware.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pins_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    reject      = 1'b0;
    sample_done = 1'b0;
    handshake   = 1'b0;
    req_bad     = (int'(req_sense_idx) >= NPINS) || req_drive_mask[req_sense_idx];
    sense_bit   = sync2_q[sense_idx_q];
    ones_sum    = ones_q + AW'(sense_bit);
    case (state_q)
      IDLE: begin
        if (req_valid && !reset) begin
          if (req_bad) begin
            reject  = 1'b1;
            state_d = RESPOND;
          end else begin
            accept  = 1'b1;
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (settle_cnt_q == CW'(SETTLE_CYCLES - 1)) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (sample_cnt_q == AW'(SAMPLE_CYCLES - 1)) begin
          sample_done = 1'b1;
          state_d     = RESPOND;
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          handshake = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = (state_q == RESPOND);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      settle_cnt_q <= '0;
      sample_cnt_q <= '0;
      ones_q       <= '0;
      sense_idx_q  <= '0;
      pins_dir     <= '0;
      pins_out     <= '0;
      rsp_level    <= 1'b0;
      rsp_stable   <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      if (accept) begin
        settle_cnt_q <= '0;
        sample_cnt_q <= '0;
        ones_q       <= '0;
        sense_idx_q  <= req_sense_idx;
        pins_dir     <= req_drive_mask;
        pins_out     <= req_drive_val & req_drive_mask;
      end
      if (state_q == SETTLE) settle_cnt_q <= settle_cnt_q + CW'(1);
      if (state_q == SAMPLE) begin
        sample_cnt_q <= sample_cnt_q + AW'(1);
        ones_q       <= ones_sum;
      end
      // Rejected requests report an error without touching the pin registers.
      if (reject) begin
        rsp_err    <= 1'b1;
        rsp_level  <= 1'b0;
        rsp_stable <= 1'b0;
      end
      if (sample_done) begin
        rsp_err    <= 1'b0;
        rsp_level  <= (int'(ones_sum) * 2) > SAMPLE_CYCLES;
        rsp_stable <= (ones_sum == '0) || (int'(ones_sum) == SAMPLE_CYCLES);
      end
      if (handshake) begin
        rsp_err    <= 1'b0;
        rsp_level  <= 1'b0;
        rsp_stable <= 1'b0;
`ifdef GATE_PROBE_AUTO_RELEASE_EN
        pins_dir   <= '0;
        pins_out   <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_gate_probe.sv
// Scoreboard bench for gate_probe: driver predicts each response from the
// planned sense-pin waveform; a decoupled monitor consumes and compares.
module tb_gate_probe;
  localparam int NPINS = 12;
  localparam int S     = 4;
  localparam int P     = 4;

  logic             CLOCK_50 = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [NPINS-1:0] req_drive_mask = '0;
  logic [NPINS-1:0] req_drive_val = '0;
  logic [3:0]       req_sense_idx = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic             rsp_level, rsp_stable, rsp_err;
  logic [NPINS-1:0] pins_dir, pins_out;
  logic [NPINS-1:0] pins_in = '0;
  logic             busy;

  gate_probe #(.NPINS(NPINS), .SETTLE_CYCLES(S), .SAMPLE_CYCLES(P)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_drive_mask(req_drive_mask), .req_drive_val(req_drive_val),
    .req_sense_idx(req_sense_idx),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_level(rsp_level), .rsp_stable(rsp_stable), .rsp_err(rsp_err),
    .pins_dir(pins_dir), .pins_out(pins_out), .pins_in(pins_in), .busy(busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc++;

  typedef struct {
    bit level;
    bit stable;
    bit err;
    int when;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  int               force_hold = -1;
  logic [NPINS-1:0] model_dir = '0;
  logic [NPINS-1:0] model_out = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at #1 after a rising edge. mode: 0 random, 1 all-0, 2 toggle, 3 all-1.
  task automatic probe(input logic [NPINS-1:0] mask, input logic [NPINS-1:0] val,
                       input logic [3:0] idx, input int mode, input int hold);
    bit   rej;
    bit   pat[S+P];
    int   ones;
    int   waited;
    exp_t e;
    waited = 0;
    while (!req_ready) begin
      @(posedge CLOCK_50); #1;
      if (++waited > 200) begin
        check("req_ready_timeout", 0, 1);
        return;
      end
    end
    rej = (int'(idx) >= NPINS);
    if (!rej) rej = mask[idx];
    for (int m = 0; m < S + P; m++)
      case (mode)
        1:       pat[m] = 1'b0;
        2:       pat[m] = bit'(m % 2);
        3:       pat[m] = 1'b1;
        default: pat[m] = bit'($urandom_range(0, 1));
      endcase
    // With a 2-flop synchronizer, sample k sees the pin as driven in cycle E+S-2+k.
    ones = 0;
    for (int k = 0; k < P; k++) ones += int'(pat[S - 2 + k]);
    e.err    = rej;
    e.level  = !rej && (ones * 2 > P);
    e.stable = !rej && (ones == 0 || ones == P);
    e.when   = cyc + 1 + (rej ? 0 : S + P);
    sb.push_back(e);
    force_hold     = hold;
    req_drive_mask = mask;
    req_drive_val  = val;
    req_sense_idx  = idx;
    req_valid      = 1'b1;
    pins_in        = NPINS'($urandom);
    @(posedge CLOCK_50); #1;
    req_valid      = 1'b0;
    req_drive_mask = NPINS'($urandom);
    req_drive_val  = NPINS'($urandom);
    req_sense_idx  = 4'($urandom);
    if (!rej) begin
      model_dir = mask;
      model_out = val & mask;
    end
    check("pins_dir_after_req", 32'(pins_dir), 32'(model_dir));
    check("pins_out_after_req", 32'(pins_out), 32'(model_out));
    if (!rej)
      for (int m = 0; m < S + P; m++) begin
        pins_in      = NPINS'($urandom);
        pins_in[idx] = pat[m];
        @(posedge CLOCK_50); #1;
      end
  endtask

  // Monitor and consumer: compares each response and applies backpressure.
  initial begin
    bit   in_rsp;
    bit   hs_prev;
    int   waitc;
    int   hold;
    exp_t e;
    logic [2:0] held;
    in_rsp = 0; hs_prev = 0; waitc = 0; hold = 0; held = '0;
    forever begin
      @(negedge CLOCK_50);
      if (reset) begin
        in_rsp = 0; hs_prev = 0; rsp_ready = 1'b0;
        continue;
      end
      if (hs_prev) begin
        hs_prev = 0;
`ifdef GATE_PROBE_AUTO_RELEASE_EN
        model_dir = '0;
        model_out = '0;
`endif
        check("rsp_valid_after_hs", 32'(rsp_valid), 0);
        check("req_ready_after_hs", 32'(req_ready), 1);
        check("pins_dir_after_hs", 32'(pins_dir), 32'(model_dir));
        check("pins_out_after_hs", 32'(pins_out), 32'(model_out));
      end
      if (rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1; waitc = 0;
          held = {rsp_level, rsp_stable, rsp_err};
          if (sb.size() == 0) begin
            check("unexpected_rsp", 1, 0);
            hold = 0;
          end else begin
            e = sb.pop_front();
            check("rsp_level", 32'(rsp_level), 32'(e.level));
            check("rsp_stable", 32'(rsp_stable), 32'(e.stable));
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            check("rsp_latency", cyc, e.when);
            hold = (force_hold >= 0) ? force_hold : $urandom_range(0, 3);
          end
        end else begin
          check("rsp_held", 32'({rsp_level, rsp_stable, rsp_err}), 32'(held));
          check("req_ready_in_rsp", 32'(req_ready), 0);
        end
        rsp_ready = (waitc >= hold);
        if (rsp_ready) begin
          hs_prev = 1;
          in_rsp  = 0;
        end
        waitc++;
      end else begin
        rsp_ready = 1'b0;
      end
    end
  end

  initial begin
    logic [NPINS-1:0] mask;
    logic [3:0]       idx;
    int               w;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("reset_req_ready", 32'(req_ready), 0);
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_pins_dir", 32'(pins_dir), 0);
    check("reset_pins_out", 32'(pins_out), 0);
    reset = 1'b0;
    #1;
    check("req_ready_after_reset", 32'(req_ready), 1);
    @(posedge CLOCK_50); #1;

    probe(12'h001, 12'h001, 4'd1, 1, 0);   // NOT probe, pin 1 low
    probe(12'h0F0, 12'h0A0, 4'd12, 0, 0);  // index out of range
    probe(12'h001, 12'h001, 4'd0, 0, 0);   // sensing a driven pin
    probe(12'h001, 12'h000, 4'd1, 2, 0);   // toggling: tie -> level 0, unstable
    probe(12'h001, 12'h001, 4'd1, 3, 5);   // constant 1 with 5-cycle backpressure
    probe(12'h000, 12'h000, 4'd15, 0, 0);  // index far out of range

    repeat (40) begin
      idx  = 4'($urandom_range(0, 13));
      mask = NPINS'($urandom);
      if (int'(idx) < NPINS && $urandom_range(0, 3) != 0) mask[idx] = 1'b0;
      probe(mask, NPINS'($urandom), idx, $urandom_range(0, 3), -1);
    end

    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(posedge CLOCK_50); #1;
      w++;
    end
    check("drain_timeout", 32'(sb.size()), 0);
    repeat (3) @(posedge CLOCK_50);
    #1;

    // Reset in the middle of SETTLE drops the probe and releases all pins.
    while (!req_ready && w < 400) begin
      @(posedge CLOCK_50); #1;
      w++;
    end
    req_drive_mask = 12'h0F0;
    req_drive_val  = 12'h0A0;
    req_sense_idx  = 4'd2;
    req_valid      = 1'b1;
    @(posedge CLOCK_50); #1;
    req_valid = 1'b0;
    check("pins_dir_before_reset", 32'(pins_dir), 32'h0F0);
    @(posedge CLOCK_50); #1;
    check("busy_in_settle", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("req_ready_during_reset", 32'(req_ready), 0);
    @(posedge CLOCK_50); #1;
    model_dir = '0;
    model_out = '0;
    check("pins_dir_after_midreset", 32'(pins_dir), 0);
    check("pins_out_after_midreset", 32'(pins_out), 0);
    check("rsp_valid_after_midreset", 32'(rsp_valid), 0);
    check("busy_after_midreset", 32'(busy), 0);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("req_ready_after_midreset", 32'(req_ready), 1);
    repeat (S + P + 4) begin
      @(negedge CLOCK_50);
      check("no_rsp_after_midreset", 32'(rsp_valid), 0);
    end

    @(posedge CLOCK_50); #1;
    probe(12'h002, 12'h002, 4'd3, 3, 0);
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(posedge CLOCK_50); #1;
      w++;
    end
    check("final_drain_timeout", 32'(sb.size()), 0);
    repeat (3) @(posedge CLOCK_50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_probe.md
# gate_probe

Pin-level probe engine sitting directly downstream of the gate finder's test sequencer. It accepts one probe request at a time: drive a set of DUT-socket pins, wait a settle window, sample one sense pin over a sampling window, and return the sampled level plus a stability flag. It owns the 12 socket pins' direction and output registers, so the sequencer only issues requests and never toggles GPIO directly.

## Interface
- `NPINS`, 12: number of socket pins handled.
- `SETTLE_CYCLES`, 50: clock cycles between driving pins and the first sample (1 µs at 50 MHz); must be ≥ 2.
- `SAMPLE_CYCLES`, 8: number of consecutive samples taken; must be ≥ 1.

Ports:
- `CLOCK_50` in 1: the only clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: probe request present.
- `req_ready` out 1: engine can accept a request.
- `req_drive_mask` in NPINS: 1 = pin driven during probe.
- `req_drive_val` in NPINS: value for driven pins.
- `req_sense_idx` in 4: index of the pin to sample.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_level` out 1: majority level of the samples.
- `rsp_stable` out 1: all samples agreed.
- `rsp_err` out 1: request rejected.
- `pins_dir` out NPINS: 1 = output enable (feeds tristate assigns).
- `pins_out` out NPINS: driven values.
- `pins_in` in NPINS: raw, asynchronous pin levels.
- `busy` out 1: state ≠ IDLE.

## Operation
- All `pins_in` bits pass through a 2-flop synchronizer. Sampling uses only the synchronized value.
- States are IDLE, SETTLE, SAMPLE and RESPOND.
- **IDLE**
  - `req_ready` = 1. A request is accepted on `req_valid & req_ready`, and mask, value and index are latched.
  - Reject when `req_sense_idx ≥ NPINS` or `req_drive_mask[req_sense_idx]` = 1. On reject: go to RESPOND with `rsp_err`=1 and `rsp_level`=`rsp_stable`=0. Pin registers are not modified.
  - Otherwise: `pins_dir` ← mask, `pins_out` ← val & mask, counter ← 0, go to SETTLE.
- **SETTLE**: count SETTLE_CYCLES cycles, then go to SAMPLE. The counter is clog2(SETTLE_CYCLES+1) bits.
- **SAMPLE**
  - Over SAMPLE_CYCLES cycles, accumulate the count of 1s on the synchronized sense pin. The accumulator is clog2(SAMPLE_CYCLES+1) bits.
  - Then go to RESPOND with:
    - `rsp_level` = (ones·2 > SAMPLE_CYCLES); a tie gives 0.
    - `rsp_stable` = (ones == 0 or ones == SAMPLE_CYCLES).
    - `rsp_err` = 0.
- **RESPOND**
  - `rsp_valid` = 1.
  - Response fields are held constant until `rsp_ready`, then the engine returns to IDLE.
  - `req_ready` = 0 throughout, so request and response never overlap.
- Pins stay driven after the response, so the sequencer can chain vectors. The next accepted request overwrites them.
- `reset` at any point, including mid-probe, has effect on the next edge:
  - state ← IDLE
  - `pins_dir` = 0, `pins_out` = 0
  - `rsp_*` = 0, `busy` = 0
  - Any pending response is dropped.
- `req_ready` is 0 while `reset` is high.

## Timing
- **Reset values:** `req_ready`=0 during reset and 1 from the first cycle after; all other outputs 0.
- **Accepted request at edge T:**
  - `pins_dir`/`pins_out` are updated at T+1.
  - SETTLE covers T+1 … T+SETTLE_CYCLES.
  - SAMPLE covers the next SAMPLE_CYCLES cycles.
  - `rsp_valid` rises at T+1+SETTLE_CYCLES+SAMPLE_CYCLES.
- **Rejected request:** `rsp_valid` at T+1.
- **Synchronizer lag:** 2 cycles, which is absorbed by the SETTLE_CYCLES ≥ 2 requirement.
- **Response handshake:** completes on the edge where `rsp_valid & rsp_ready`. `req_ready` = 1 on the following cycle.
- **Throughput (default parameters):** at best one probe per SETTLE_CYCLES+SAMPLE_CYCLES+2 cycles.

## Configuration
- `GATE_PROBE_AUTO_RELEASE_EN` defined: on the response handshake edge, `pins_dir` ← 0 and `pins_out` ← 0. All socket pins are high-Z by the first IDLE cycle.
- Not defined: pins keep their last drive until the next accepted non-rejected request or reset.

## Test plan
Bench parameters: SETTLE_CYCLES=4, SAMPLE_CYCLES=4.
- **NOT probe:** mask=0x001, val=0x001, idx=1, `pins_in[1]`=0 → `pins_dir`=0x001 and `pins_out`=0x001 at T+1; `rsp_valid` at T+9 with level=0, stable=1, err=0.
- **Bad index:** idx=12 → `rsp_valid` at T+1 with err=1; `pins_dir` unchanged from the prior value.
- **Sensing a driven pin:** idx=0 with mask=0x001 → err=1, no pin change.
- **Unstable input:** `pins_in[1]` toggling every cycle through SAMPLE → stable=0, level=0 (2 of 4 ones, tie). Constant 1 → level=1, stable=1.
- **Response backpressure:** `rsp_ready` held low 5 cycles → `rsp_*` constant and `req_ready`=0. After `rsp_ready`=1, `req_ready`=1 the next cycle.
- **Reset mid-SETTLE:**
  - `reset` pulsed → next cycle `pins_dir`=0, `rsp_valid`=0, `busy`=0; `req_ready`=1 after `reset` drops.
  - With the macro defined, `pins_dir`=0 also follows every response handshake.
